core_lsu_pipe: RTL

CORE_LSU_PIPE -- requirements
Module: core_lsu_pipe

---
 rtl/core_lsu_pipe.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/core_lsu_pipe.sv
// Load/store unit: decodes IDU memory ops, issues bus requests, tracks outstanding
// loads in an in-order pending table and returns formatted load data to the WBU.
`timescale 1ns/1ps
module core_lsu_pipe #(
  parameter int DEPTH     = 4,
  parameter int ALIGN_CHK = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         lsu_rx_valid,
  output logic                         lsu_rx_ready,
  input  logic [6:0]                   lsu_rx_opcode,
  input  logic [2:0]                   lsu_rx_func3,
  input  logic [31:0]                  lsu_rx_rs1_data,
  input  logic [31:0]                  lsu_rx_rs2_data,
  input  logic [4:0]                   lsu_rx_rd_idx,
  input  logic [31:0]                  lsu_rx_imme,
  output logic                         lsu_req_vld,
  output logic                         lsu_req_wen,
  output logic [3:0]                   lsu_req_wstrb,
  output logic [31:0]                  lsu_req_addr,
  output logic [31:0]                  lsu_req_wdata,
  input  logic                         lsu_req_rdy,
  input  logic                         lsu_resp_vld,
  input  logic [31:0]                  lsu_resp_rdata,
  output logic                         lsu_resp_rdy,
  output logic                         lsu_tx_valid,
  output logic [31:0]                  lsu_tx_data,
  output logic [4:0]                   lsu_tx_rd_idx,
  input  logic                         lsu_tx_ready,
  output logic                         lsu_exc_vld,
  output logic [31:0]                  lsu_exc_addr,
  output logic                         lsu_busy,
  output logic [$clog2(DEPTH+1)-1:0]   dbg_count
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and payload is only meaningful while valid.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic          is_load, is_store, mem_op;
  logic          sz_byte, sz_half, sz_word;
  logic          misaligned, trap, full, push, pop;
  logic [31:0]   addr;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr, rd_ptr;

  logic [4:0]    tbl_rd  [DEPTH];
  logic [2:0]    tbl_f3  [DEPTH];
  logic [1:0]    tbl_off [DEPTH];

  logic [2:0]    head_f3;
  logic [31:0]   shifted, load_data;

  always_comb begin
    is_load    = (lsu_rx_opcode == 7'b0000011);
    is_store   = (lsu_rx_opcode == 7'b0100011);
    mem_op     = is_load | is_store;
    addr       = lsu_rx_rs1_data + lsu_rx_imme;
    // LBU/LHU only exist for loads; every unlisted func3 falls back to a word access
    sz_byte    = (lsu_rx_func3 == 3'b000) | (is_load & (lsu_rx_func3 == 3'b100));
    sz_half    = (lsu_rx_func3 == 3'b001) | (is_load & (lsu_rx_func3 == 3'b101));
    sz_word    = !sz_byte & !sz_half;
    misaligned = (sz_half & addr[0]) | (sz_word & (addr[1:0] != 2'b00));
    trap       = mem_op & misaligned & (ALIGN_CHK != 0);
    full       = (count == CW'(DEPTH));

    lsu_req_vld   = lsu_rx_valid & !trap & (is_store | (is_load & !full));
    lsu_rx_ready  = trap | !mem_op | (lsu_req_rdy & (is_store | !full));
    lsu_req_wen   = is_store;
    lsu_req_addr  = addr;
    lsu_req_wstrb = 4'b1111;
    lsu_req_wdata = lsu_rx_rs2_data;
    if (sz_byte) begin
      lsu_req_wstrb = 4'b0001 << addr[1:0];
      lsu_req_wdata = {4{lsu_rx_rs2_data[7:0]}};
    end else if (sz_half) begin
      lsu_req_wstrb = 4'b0011 << addr[1:0];
      lsu_req_wdata = {2{lsu_rx_rs2_data[15:0]}};
    end

    push         = lsu_req_vld & lsu_req_rdy & is_load;
    lsu_resp_rdy = (count != '0) & (!lsu_tx_valid | lsu_tx_ready);
    pop          = lsu_resp_vld & lsu_resp_rdy;
    lsu_busy     = (count != '0) | lsu_tx_valid;
    dbg_count    = count;
  end

  // Response formatting uses the table head, which is the oldest outstanding load.
  always_comb begin
    head_f3 = tbl_f3[rd_ptr];
    shifted = lsu_resp_rdata >> {tbl_off[rd_ptr], 3'b000};
    case (head_f3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = lsu_resp_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tbl_rd[wr_ptr]  <= lsu_rx_rd_idx;
      tbl_f3[wr_ptr]  <= lsu_rx_func3;
      tbl_off[wr_ptr] <= addr[1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count         <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      lsu_tx_valid  <= 1'b0;
      lsu_tx_data   <= '0;
      lsu_tx_rd_idx <= '0;
      lsu_exc_vld   <= 1'b0;
      lsu_exc_addr  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (pop) begin
        lsu_tx_valid  <= 1'b1;
        lsu_tx_data   <= load_data;
        lsu_tx_rd_idx <= tbl_rd[rd_ptr];
      end else if (lsu_tx_ready) begin
        lsu_tx_valid  <= 1'b0;
      end
      // A trapped op is always accepted, so valid alone marks its handshake
      lsu_exc_vld <= lsu_rx_valid & trap;
      if (lsu_rx_valid & trap) lsu_exc_addr <= addr;
    end
  end

endmodule
